font_rom_arbiter: RTL and testbench

//  Shares the single character font ROM between two pixel pipelines: the static label text

---
 rtl/font_arb_pkg.sv | 34 +++
 rtl/font_rd_pipe.sv | 64 ++++++
 rtl/font_rom_arbiter.sv | 122 ++++++++++++
 tb/tb_font_rom_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/font_arb_pkg.sv
// Shared definitions for the font ROM arbiter: default widths, requester IDs and
// the field layout of a font ROM address {sel_car[3:0], ad[1:0], row[3:0]}.
package font_arb_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 8;

  // Requester identifiers carried alongside each read through the pipeline.
  typedef enum logic {
    REQ_TEXT  = 1'b0,
    REQ_DIGIT = 1'b1
  } req_id_e;

  // Address field slices.
  localparam int unsigned ROW_LSB = 0;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned AD_LSB  = 4;
  localparam int unsigned AD_W    = 2;
  localparam int unsigned SEL_LSB = 6;
  localparam int unsigned SEL_W   = 4;

  function automatic logic [SEL_W-1:0] addr_sel_car(input logic [AW_DEF-1:0] addr);
    return addr[SEL_LSB +: SEL_W];
  endfunction

  function automatic logic [AD_W-1:0] addr_ad(input logic [AW_DEF-1:0] addr);
    return addr[AD_LSB +: AD_W];
  endfunction

  function automatic logic [ROW_W-1:0] addr_row(input logic [AW_DEF-1:0] addr);
    return addr[ROW_LSB +: ROW_W];
  endfunction

endpackage

// File: rtl/font_rd_pipe.sv
// Read-return pipeline: carries the requester ID of each issued read alongside the
// ROM latency and captures the ROM word into a shared registered rdata with a
// one-cycle valid steered to the owning requester.
module font_rd_pipe
  import font_arb_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          issue_i,
  input  req_id_e       issue_id_i,
  input  logic [DW-1:0] rom_data_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_text_o,
  output logic          rvalid_digit_o
);

  // Stage 0 lines up with rom_en; stage RD_LAT lines up with valid rom_data.
  localparam int unsigned Depth = RD_LAT + 1;

  logic [Depth-1:0] vld_q, vld_d;
  logic [Depth-1:0] id_q, id_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             rvalid_text_q, rvalid_text_d;
  logic             rvalid_digit_q, rvalid_digit_d;
  logic             tail_vld;
  logic             tail_id;

  assign tail_vld = vld_q[Depth-1];
  assign tail_id  = id_q[Depth-1];

  // Shift ID/valid along; capture rom_data when the tail stage holds a live read.
  always_comb begin
    vld_d          = {vld_q[Depth-2:0], issue_i};
    id_d           = {id_q[Depth-2:0], logic'(issue_id_i)};
    rdata_d        = tail_vld ? rom_data_i : rdata_q;
    rvalid_text_d  = tail_vld && (tail_id == logic'(REQ_TEXT));
    rvalid_digit_d = tail_vld && (tail_id == logic'(REQ_DIGIT));
  end

  // Pipeline state; reset discards every in-flight read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q          <= '0;
      id_q           <= '0;
      rdata_q        <= '0;
      rvalid_text_q  <= 1'b0;
      rvalid_digit_q <= 1'b0;
    end else begin
      vld_q          <= vld_d;
      id_q           <= id_d;
      rdata_q        <= rdata_d;
      rvalid_text_q  <= rvalid_text_d;
      rvalid_digit_q <= rvalid_digit_d;
    end
  end

  assign rdata_o        = rdata_q;
  assign rvalid_text_o  = rvalid_text_q;
  assign rvalid_digit_o = rvalid_digit_q;

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one font ROM between the label text generator and the
// RTC digit renderer: one ROM access per clock, data steered back per requester.
// Optional conflict statistics counter enabled by defining FONT_ARB_STATS_EN.
module font_rom_arbiter
  import font_arb_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_text,
  input  logic [AW-1:0] addr_text,
  output logic          gnt_text,
  output logic          rvalid_text,
  input  logic          req_digit,
  input  logic [AW-1:0] addr_digit,
  output logic          gnt_digit,
  output logic          rvalid_digit,
  output logic [DW-1:0] rdata,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [15:0]   conflict_cnt
);

  req_id_e       last_winner_q, last_winner_d;
  logic          rom_en_q, rom_en_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          issue;
  req_id_e       issue_id;

  // Grant decision: a lone request wins; on conflict the previous loser wins.
  // Grants are masked while reset is held so every output reads 0.
  always_comb begin
    gnt_text  = 1'b0;
    gnt_digit = 1'b0;
    if (!reset) begin
      if (req_text && req_digit) begin
        gnt_text  = (last_winner_q == REQ_DIGIT);
        gnt_digit = (last_winner_q == REQ_TEXT);
      end else begin
        gnt_text  = req_text;
        gnt_digit = req_digit;
      end
    end
  end

  assign issue    = gnt_text | gnt_digit;
  assign issue_id = gnt_digit ? REQ_DIGIT : REQ_TEXT;

  // Next ROM strobe/address and round-robin pointer; address holds when idle.
  always_comb begin
    last_winner_d = last_winner_q;
    rom_en_d      = issue;
    rom_addr_d    = rom_addr_q;
    if (gnt_text) begin
      last_winner_d = REQ_TEXT;
      rom_addr_d    = addr_text;
    end else if (gnt_digit) begin
      last_winner_d = REQ_DIGIT;
      rom_addr_d    = addr_digit;
    end
  end

  // Arbiter and ROM interface registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner_q <= REQ_DIGIT;
      rom_en_q      <= 1'b0;
      rom_addr_q    <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      rom_en_q      <= rom_en_d;
      rom_addr_q    <= rom_addr_d;
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;

  font_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i          (clk),
    .rst_i          (reset),
    .issue_i        (issue),
    .issue_id_i     (issue_id),
    .rom_data_i     (rom_data),
    .rdata_o        (rdata),
    .rvalid_text_o  (rvalid_text),
    .rvalid_digit_o (rvalid_digit)
  );

`ifdef FONT_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating count of cycles where both requesters contend.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (req_text && req_digit && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt_q <= 16'h0000;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter with a scoreboard of expected read returns.
module tb_font_rom_arbiter;

  localparam int unsigned AW     = 10;
  localparam int unsigned DW     = 8;
  localparam int unsigned RD_LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_text = 1'b0;
  logic [AW-1:0] addr_text = '0;
  logic          gnt_text;
  logic          rvalid_text;
  logic          req_digit = 1'b0;
  logic [AW-1:0] addr_digit = '0;
  logic          gnt_digit;
  logic          rvalid_digit;
  logic [DW-1:0] rdata;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [15:0]   conflict_cnt;

  always #5 clk = ~clk;

  font_rom_arbiter #(
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_text     (req_text),
    .addr_text    (addr_text),
    .gnt_text     (gnt_text),
    .rvalid_text  (rvalid_text),
    .req_digit    (req_digit),
    .addr_digit   (addr_digit),
    .gnt_digit    (gnt_digit),
    .rvalid_digit (rvalid_digit),
    .rdata        (rdata),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .conflict_cnt (conflict_cnt)
  );

  // ROM model: data = addr[7:0] ^ 8'hA5, RD_LAT cycles after rom_en.
  logic [DW-1:0] rom_q [RD_LAT];
  always @(posedge clk) begin
    if (rom_en) rom_q[0] <= rom_addr[7:0] ^ 8'hA5;
    for (int i = 1; i < RD_LAT; i++) rom_q[i] <= rom_q[i-1];
  end
  assign rom_data = rom_q[RD_LAT-1];

  typedef struct {
    int          due;
    logic        id;    // 1 = digit
    logic [7:0]  data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic        last_digit_exp = 1'b1;
  logic        rom_en_exp = 1'b0;
  logic [9:0]  rom_addr_exp = '0;
  logic [7:0]  rdata_exp = '0;
  logic [15:0] cnt_exp = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: check grants before the edge, update the model, check registered
  // outputs on the following falling edge. Inputs are changed by the caller after.
  task automatic step();
    logic       gt, gd, rt, rd;
    logic [9:0] a;
    exp_t       e;
    #1;
    gt = 1'b0;
    gd = 1'b0;
    if (reset) begin
      sb.delete();
      last_digit_exp = 1'b1;
    end else if (req_text && req_digit) begin
      gt = last_digit_exp;
      gd = !last_digit_exp;
    end else begin
      gt = req_text;
      gd = req_digit;
    end
    check("gnt_text", gnt_text, gt);
    check("gnt_digit", gnt_digit, gd);
    a = gd ? addr_digit : addr_text;
    if (gt || gd) sb.push_back('{cyc + RD_LAT + 2, gd, a[7:0] ^ 8'hA5});
    @(posedge clk);
    cyc++;
    if (reset) begin
      rom_en_exp   = 1'b0;
      rom_addr_exp = '0;
      rdata_exp    = '0;
      cnt_exp      = '0;
    end else begin
      rom_en_exp = gt || gd;
      if (gt || gd) begin
        rom_addr_exp   = a;
        last_digit_exp = gd;
      end
`ifdef FONT_ARB_STATS_EN
      if (req_text && req_digit && cnt_exp != 16'hFFFF) cnt_exp++;
`endif
    end
    @(negedge clk);
    rt = 1'b0;
    rd = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      rt = !e.id;
      rd = e.id;
      rdata_exp = e.data;
    end
    check("rvalid_text", rvalid_text, rt);
    check("rvalid_digit", rvalid_digit, rd);
    check("rdata", rdata, rdata_exp);
    check("rom_en", rom_en, rom_en_exp);
    check("rom_addr", rom_addr, rom_addr_exp);
    check("conflict_cnt", conflict_cnt, cnt_exp);
  endtask

  task automatic idle(input int n);
    req_text  = 1'b0;
    req_digit = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    @(negedge clk);
    // Reset held with random requests: everything stays 0.
    repeat (4) begin
      req_text   = 1'($urandom_range(0, 1));
      req_digit  = 1'($urandom_range(0, 1));
      addr_text  = 10'($urandom);
      addr_digit = 10'($urandom);
      step();
    end
    // Release with both requesting: text wins first.
    reset      = 1'b0;
    req_text   = 1'b1;
    req_digit  = 1'b1;
    addr_text  = 10'h010;
    addr_digit = 10'h020;
    #1 check("first_conflict_text", gnt_text, 1'b1);
    step();
    idle(4);

    // Single text read of 10'h12A -> rdata 8'h8F.
    req_text  = 1'b1;
    addr_text = 10'h12A;
    step();
    idle(1);
    check("t1_addr_12A", rom_addr, 10'h12A);
    idle(1);
    check("t3_rdata_8F", rdata, 8'h8F);
    idle(3);

    // Digit back-to-back 1..4 -> A4, A7, A6, A1.
    req_digit = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      addr_digit = 10'(i);
      step();
    end
    idle(5);

    // Both high for 6 cycles: strict alternation starting with text.
    req_text  = 1'b1;
    req_digit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr_text  = 10'h100 + 10'(i);
      addr_digit = 10'h200 + 10'(i);
      #1 check("alt_gnt_text", gnt_text, (i % 2 == 0) ? 1'b1 : 1'b0);
      step();
    end
    idle(5);

    // Reset one cycle after a grant: read is discarded, text wins next conflict.
    req_text  = 1'b1;
    addr_text = 10'h055;
    step();
    req_text = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    idle(5);
    req_text  = 1'b1;
    req_digit = 1'b1;
    #1 check("post_reset_text", gnt_text, 1'b1);
    step();
    idle(5);

    // Conflict statistics.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_text  = 1'b1;
    req_digit = 1'b1;
    repeat (10) step();
`ifdef FONT_ARB_STATS_EN
    check("cnt_10", conflict_cnt, 16'd10);
    force dut.conflict_cnt_q = 16'hFFFE;
    #1 release dut.conflict_cnt_q;
    cnt_exp = 16'hFFFE;
    repeat (3) step();
    check("cnt_sat", conflict_cnt, 16'hFFFF);
`else
    check("cnt_off", conflict_cnt, 16'h0000);
`endif
    idle(5);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
